wr_stage_pipe: RTL and testbench
================================

WR_STAGE_PIPE -- requirements
Module: wr_stage_pipe

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; SHALL be a multiple of 32.
REQ-002 Parameter REG_AW, default 5, register-address width.
REQ-003 Parameter CNT_W, default 32, width of both statistics counters.
REQ-004 Parameter OVF_SUPPRESS, default 1; when 1, an overflowing instruction SHALL NOT write back.
REQ-005 Parameter ZERO_REG, default 1; when 1, writes to address 0 SHALL be suppressed.
REQ-006 Clock and reset: one clock; reset is synchronous and active-high.
REQ-007 Ports, in this order:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  MEM stage presents an instruction
- hold  in  1  freeze the WR register
- flush  in  1  kill the incoming and held entry
- in_dout  in  DATA_W  raw memory read data
- in_aluout  in  DATA_W  ALU result
- in_rw  in  REG_AW  destination register
- in_overflow  in  1  ALU overflow
- in_memtoreg  in  1  select memory data
- in_regwr  in  1  register write request
- in_ldsize  in  2  0=byte, 1=half, 2=word(32), 3=full DATA_W
- in_ldsigned  in  1  sign-extend loaded data
- in_byteoff  in  log2(DATA_W/8)  byte address within the data word
- out_regdin  out  DATA_W  write-back data
- out_rw  out  REG_AW  write-back address
- out_regwe  out  1  write-back enable
- ovf_exc  out  1  one-cycle pulse on a suppressed overflow
- retire_cnt  out  CNT_W  retired instructions
- ovf_cnt  out  CNT_W  suppressed overflows

Function
REQ-008 The block SHALL register all in_* fields plus a valid bit and a fresh bit (one-cycle latency, input to out_*).
REQ-009 Register update priority: flush (valid_q<=0, fresh_q<=0) > hold (contents frozen, fresh_q<=0) > capture (fields<=inputs, valid_q<=in_valid, fresh_q<=in_valid).
REQ-010 An entry SHALL assert outputs only while fresh_q=1; a held entry SHALL NOT write or count again.
REQ-011 out_regwe SHALL equal fresh_q & regwr_q & ~(OVF_SUPPRESS & ovf_q) & ~(ZERO_REG & (rw_q==0)).
REQ-012 out_regdin SHALL be the aligned load value when memtoreg_q=1, else aluout_q; out_rw SHALL equal rw_q.
REQ-013 Alignment is little-endian; the byte lane SHALL be byteoff_q, the half lane byteoff_q with bit0 ignored, and the word lane byteoff_q with bits[1:0] ignored.
REQ-014 Byte, half and word loads SHALL zero- or sign-extend to DATA_W per ldsigned_q; ldsize 3 SHALL pass in_dout unchanged.
REQ-015 ovf_exc SHALL equal fresh_q & regwr_q & ovf_q & OVF_SUPPRESS, combinationally.
REQ-016 retire_cnt SHALL increment by 1 on every clock edge where fresh_q=1, wrapping at 2^CNT_W.
REQ-017 ovf_cnt SHALL increment on every clock edge where ovf_exc=1, saturating at all-ones.
REQ-018 If flush and hold are both asserted, flush SHALL win; an entry already fresh in that cycle still retires.

Reset
REQ-019 rst SHALL clear valid_q, fresh_q, all registered fields, retire_cnt and ovf_cnt.
REQ-020 After reset, all outputs SHALL be 0 until the first capture; rst SHALL override hold, flush and capture in the same cycle.

Structure
REQ-021 Package wr_pkg SHALL hold the ldsize constants LD_B, LD_H, LD_W, LD_FULL and the alignment function prototypes.
REQ-022 Sub-module load_align SHALL be a combinational block (dout, size, signed, byteoff -> aligned data), parameterised by DATA_W.

Verification
REQ-023 Capture regwr=1, aluout=0x12345678, rw=3 -> next cycle out_regwe=1, out_rw=3, out_regdin=0x12345678, retire_cnt=1.
REQ-024 Load dout=0x80FF7F01, byteoff=2, byte signed -> 0xFFFFFFFF; half unsigned byteoff=2 -> 0x000080FF; byte unsigned byteoff=1 -> 0x0000007F.
REQ-025 regwr=1, overflow=1, OVF_SUPPRESS=1 -> out_regwe=0, ovf_exc=1 for one cycle, ovf_cnt=1; with OVF_SUPPRESS=0 -> out_regwe=1, ovf_cnt=0.
REQ-026 Capture, then hold for 3 cycles -> out_regwe high only in the first cycle, retire_cnt +1 total.
REQ-027 Flush with hold, in_valid=1 -> no write-back next cycle; rst mid-stream -> all outputs 0 and counters 0 next cycle.
REQ-028 Write to rw=0 with ZERO_REG=1 -> out_regwe=0, retire_cnt still increments.

Source files
------------

// File: rtl/wr_pkg.sv
// Shared definitions for the write-back stage: load-size encodings and
// the lane-selection helper used by the load aligner.
package wr_pkg;

  localparam logic [1:0] LD_B    = 2'd0;
  localparam logic [1:0] LD_H    = 2'd1;
  localparam logic [1:0] LD_W    = 2'd2;
  localparam logic [1:0] LD_FULL = 2'd3;

  localparam int OFF_MAX_W = 8;

  // Bit shift that brings the addressed lane to bit 0; low offset bits are
  // dropped according to the access size so lanes stay naturally aligned.
  function automatic logic [10:0] lane_shift(input logic [OFF_MAX_W-1:0] byteoff,
                                             input logic [1:0] size);
    logic [OFF_MAX_W-1:0] off_s;
    case (size)
      LD_B:    off_s = byteoff;
      LD_H:    off_s = byteoff & 8'hFE;
      LD_W:    off_s = byteoff & 8'hFC;
      default: off_s = 8'h00;
    endcase
    return {off_s, 3'b000};
  endfunction

endpackage

// File: rtl/load_align.sv
// Combinational little-endian load aligner: picks the addressed byte, half
// or word lane and zero- or sign-extends it to the datapath width.
module load_align
  import wr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] dout,
  input  logic [1:0]        size,
  input  logic              is_signed,
  input  logic [OFF_W-1:0]  byteoff,
  output logic [DATA_W-1:0] aligned
);

  logic [OFF_MAX_W-1:0] off_ext_s;
  logic [10:0]          shamt_s;
  logic [DATA_W-1:0]    shifted_s;

  assign off_ext_s = OFF_MAX_W'(byteoff);
  assign shamt_s   = lane_shift(off_ext_s, size);
  assign shifted_s = dout >> shamt_s;

  // Lane extension; a full-width load bypasses the shifter entirely.
  always_comb begin
    aligned = dout;
    case (size)
      LD_B:    aligned = is_signed ? DATA_W'($signed(shifted_s[7:0]))
                                   : DATA_W'(shifted_s[7:0]);
      LD_H:    aligned = is_signed ? DATA_W'($signed(shifted_s[15:0]))
                                   : DATA_W'(shifted_s[15:0]);
      LD_W:    aligned = is_signed ? DATA_W'($signed(shifted_s[31:0]))
                                   : DATA_W'(shifted_s[31:0]);
      LD_FULL: aligned = dout;
      default: aligned = dout;
    endcase
  end

endmodule

// File: rtl/wr_stage_pipe.sv
// Write-back pipeline register: captures the MEM-stage result, aligns loads,
// gates register writes and keeps retire / suppressed-overflow statistics.
module wr_stage_pipe
  import wr_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int REG_AW       = 5,
  parameter int CNT_W        = 32,
  parameter bit OVF_SUPPRESS = 1'b1,
  parameter bit ZERO_REG     = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        hold,
  input  logic                        flush,
  input  logic [DATA_W-1:0]           in_dout,
  input  logic [DATA_W-1:0]           in_aluout,
  input  logic [REG_AW-1:0]           in_rw,
  input  logic                        in_overflow,
  input  logic                        in_memtoreg,
  input  logic                        in_regwr,
  input  logic [1:0]                  in_ldsize,
  input  logic                        in_ldsigned,
  input  logic [$clog2(DATA_W/8)-1:0] in_byteoff,
  output logic [DATA_W-1:0]           out_regdin,
  output logic [REG_AW-1:0]           out_rw,
  output logic                        out_regwe,
  output logic                        ovf_exc,
  output logic [CNT_W-1:0]            retire_cnt,
  output logic [CNT_W-1:0]            ovf_cnt
);

  localparam int OFF_W = $clog2(DATA_W/8);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              valid_r, fresh_r;
  logic [DATA_W-1:0] dout_r, aluout_r;
  logic [REG_AW-1:0] rw_r;
  logic              ovf_r, memtoreg_r, regwr_r, ldsigned_r;
  logic [1:0]        ldsize_r;
  logic [OFF_W-1:0]  byteoff_r;
  logic [CNT_W-1:0]  retire_cnt_r, ovf_cnt_r;

  logic [DATA_W-1:0] aligned_s;
  logic              ovf_block_s, zero_block_s, ovf_exc_s;

  // Pipeline entry: flush beats hold beats capture; fields survive a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r    <= 1'b0;
      fresh_r    <= 1'b0;
      dout_r     <= {DATA_W{1'b0}};
      aluout_r   <= {DATA_W{1'b0}};
      rw_r       <= {REG_AW{1'b0}};
      ovf_r      <= 1'b0;
      memtoreg_r <= 1'b0;
      regwr_r    <= 1'b0;
      ldsize_r   <= 2'b00;
      ldsigned_r <= 1'b0;
      byteoff_r  <= {OFF_W{1'b0}};
    end else if (flush) begin
      valid_r <= 1'b0;
      fresh_r <= 1'b0;
    end else if (hold) begin
      fresh_r <= 1'b0;
    end else begin
      valid_r    <= in_valid;
      fresh_r    <= in_valid;
      dout_r     <= in_dout;
      aluout_r   <= in_aluout;
      rw_r       <= in_rw;
      ovf_r      <= in_overflow;
      memtoreg_r <= in_memtoreg;
      regwr_r    <= in_regwr;
      ldsize_r   <= in_ldsize;
      ldsigned_r <= in_ldsigned;
      byteoff_r  <= in_byteoff;
    end
  end

  load_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_load_align (
    .dout      (dout_r),
    .size      (ldsize_r),
    .is_signed (ldsigned_r),
    .byteoff   (byteoff_r),
    .aligned   (aligned_s)
  );

  assign ovf_block_s  = OVF_SUPPRESS & ovf_r;
  assign zero_block_s = ZERO_REG & (rw_r == {REG_AW{1'b0}});
  assign ovf_exc_s    = fresh_r & regwr_r & ovf_r & OVF_SUPPRESS;

  // Statistics: retire count wraps, suppressed-overflow count saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_r <= {CNT_W{1'b0}};
      ovf_cnt_r    <= {CNT_W{1'b0}};
    end else begin
      if (fresh_r) begin
        retire_cnt_r <= retire_cnt_r + CNT_ONE;
      end else begin
        retire_cnt_r <= retire_cnt_r;
      end
      if (ovf_exc_s && (ovf_cnt_r != {CNT_W{1'b1}})) begin
        ovf_cnt_r <= ovf_cnt_r + CNT_ONE;
      end else begin
        ovf_cnt_r <= ovf_cnt_r;
      end
    end
  end

  // valid_r is implied by fresh_r; keeping it in the term makes that explicit.
  assign out_regwe  = valid_r & fresh_r & regwr_r & ~ovf_block_s & ~zero_block_s;
  assign out_regdin = memtoreg_r ? aligned_s : aluout_r;
  assign out_rw     = rw_r;
  assign ovf_exc    = ovf_exc_s;
  assign retire_cnt = retire_cnt_r;
  assign ovf_cnt    = ovf_cnt_r;

endmodule

// File: tb/tb_wr_stage_pipe.sv
// Directed bench for wr_stage_pipe; a second instance with overflow
// suppression disabled shares the same stimulus.
module tb_wr_stage_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, hold, flush;
  logic [31:0] in_dout, in_aluout;
  logic [4:0]  in_rw;
  logic        in_overflow, in_memtoreg, in_regwr, in_ldsigned;
  logic [1:0]  in_ldsize, in_byteoff;

  logic [31:0] out_regdin, n_regdin;
  logic [4:0]  out_rw, n_rw;
  logic        out_regwe, n_regwe, ovf_exc, n_ovf_exc;
  logic [31:0] retire_cnt, ovf_cnt, n_retire_cnt, n_ovf_cnt;

  int checks = 0;
  int errors = 0;
  int exp_retire = 0;

  always #5 clk = ~clk;

  wr_stage_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .hold(hold), .flush(flush),
    .in_dout(in_dout), .in_aluout(in_aluout), .in_rw(in_rw),
    .in_overflow(in_overflow), .in_memtoreg(in_memtoreg), .in_regwr(in_regwr),
    .in_ldsize(in_ldsize), .in_ldsigned(in_ldsigned), .in_byteoff(in_byteoff),
    .out_regdin(out_regdin), .out_rw(out_rw), .out_regwe(out_regwe),
    .ovf_exc(ovf_exc), .retire_cnt(retire_cnt), .ovf_cnt(ovf_cnt)
  );

  wr_stage_pipe #(.OVF_SUPPRESS(1'b0)) dut_nosup (
    .clk(clk), .rst(rst), .in_valid(in_valid), .hold(hold), .flush(flush),
    .in_dout(in_dout), .in_aluout(in_aluout), .in_rw(in_rw),
    .in_overflow(in_overflow), .in_memtoreg(in_memtoreg), .in_regwr(in_regwr),
    .in_ldsize(in_ldsize), .in_ldsigned(in_ldsigned), .in_byteoff(in_byteoff),
    .out_regdin(n_regdin), .out_rw(n_rw), .out_regwe(n_regwe),
    .ovf_exc(n_ovf_exc), .retire_cnt(n_retire_cnt), .ovf_cnt(n_ovf_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; in_valid = 1'b0; hold = 1'b0; flush = 1'b0;
    in_dout = 32'h0; in_aluout = 32'h0; in_rw = 5'd0;
    in_overflow = 1'b0; in_memtoreg = 1'b0; in_regwr = 1'b0;
    in_ldsize = 2'd0; in_ldsigned = 1'b0; in_byteoff = 2'd0;
  endtask

  task automatic alu_op(input logic [4:0] rw, input logic [31:0] val, input logic ovf);
    idle();
    in_valid = 1'b1; in_regwr = 1'b1; in_rw = rw; in_aluout = val; in_overflow = ovf;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({out_regwe, out_regdin, out_rw, ovf_exc} !== 39'h0) begin
      $display("FAIL reset_outputs got we=%b din=%h rw=%0d exc=%b want 0", out_regwe, out_regdin, out_rw, ovf_exc);
      errors++;
    end
    checks++;
    if (retire_cnt !== 32'd0 || ovf_cnt !== 32'd0) begin
      $display("FAIL reset_counters got retire=%0d ovf=%0d want 0 0", retire_cnt, ovf_cnt);
      errors++;
    end
  endtask

  task automatic test_alu_writeback();
    alu_op(5'd3, 32'h12345678, 1'b0);
    step();
    idle();
    checks++;
    if (out_regwe !== 1'b1 || out_rw !== 5'd3 || out_regdin !== 32'h12345678) begin
      $display("FAIL alu_wb got we=%b rw=%0d din=%h want 1 3 12345678", out_regwe, out_rw, out_regdin);
      errors++;
    end
    step();
    exp_retire++;
    checks++;
    if (retire_cnt !== 32'd1 || out_regwe !== 1'b0) begin
      $display("FAIL alu_retire got retire=%0d we=%b want 1 0", retire_cnt, out_regwe);
      errors++;
    end
  endtask

  typedef struct {
    logic [1:0]  sz;
    logic        sgn;
    logic [1:0]  off;
    logic [31:0] exp;
  } ld_vec_t;

  task automatic test_load_align();
    ld_vec_t v[7];
    v[0] = '{2'd0, 1'b1, 2'd2, 32'hFFFFFFFF};
    v[1] = '{2'd1, 1'b0, 2'd2, 32'h000080FF};
    v[2] = '{2'd0, 1'b0, 2'd1, 32'h0000007F};
    v[3] = '{2'd0, 1'b1, 2'd0, 32'h00000001};
    v[4] = '{2'd1, 1'b1, 2'd3, 32'hFFFF80FF};
    v[5] = '{2'd2, 1'b1, 2'd3, 32'h80FF7F01};
    v[6] = '{2'd3, 1'b0, 2'd1, 32'h80FF7F01};
    for (int i = 0; i < 7; i++) begin
      idle();
      in_valid = 1'b1; in_regwr = 1'b1; in_memtoreg = 1'b1; in_rw = 5'd9;
      in_dout = 32'h80FF7F01; in_aluout = 32'hDEADBEEF;
      in_ldsize = v[i].sz; in_ldsigned = v[i].sgn; in_byteoff = v[i].off;
      step();
      exp_retire++;
      checks++;
      if (out_regdin !== v[i].exp || out_regwe !== 1'b1) begin
        $display("FAIL load_%0d got din=%h we=%b want %h 1", i, out_regdin, out_regwe, v[i].exp);
        errors++;
      end
    end
    idle();
    step();
  endtask

  task automatic test_overflow();
    alu_op(5'd5, 32'h7FFFFFFF, 1'b1);
    step();
    idle();
    exp_retire++;
    checks++;
    if (out_regwe !== 1'b0 || ovf_exc !== 1'b1) begin
      $display("FAIL ovf_suppress got we=%b exc=%b want 0 1", out_regwe, ovf_exc);
      errors++;
    end
    checks++;
    if (n_regwe !== 1'b1 || n_ovf_exc !== 1'b0) begin
      $display("FAIL ovf_nosup got we=%b exc=%b want 1 0", n_regwe, n_ovf_exc);
      errors++;
    end
    step();
    checks++;
    if (ovf_exc !== 1'b0 || ovf_cnt !== 32'd1 || n_ovf_cnt !== 32'd0) begin
      $display("FAIL ovf_count got exc=%b cnt=%0d nosup_cnt=%0d want 0 1 0", ovf_exc, ovf_cnt, n_ovf_cnt);
      errors++;
    end
  endtask

  task automatic test_hold();
    alu_op(5'd7, 32'h000000AA, 1'b0);
    step();
    exp_retire++;
    checks++;
    if (out_regwe !== 1'b1 || out_regdin !== 32'h000000AA) begin
      $display("FAIL hold_first got we=%b din=%h want 1 000000aa", out_regwe, out_regdin);
      errors++;
    end
    alu_op(5'd8, 32'h55555555, 1'b0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_regwe !== 1'b0 || out_rw !== 5'd7) begin
        $display("FAIL hold_cycle_%0d got we=%b rw=%0d want 0 7", i, out_regwe, out_rw);
        errors++;
      end
    end
    idle();
    step();
    checks++;
    if (retire_cnt !== 32'(exp_retire)) begin
      $display("FAIL hold_retire got %0d want %0d", retire_cnt, exp_retire);
      errors++;
    end
  endtask

  task automatic test_flush();
    alu_op(5'd10, 32'h00000010, 1'b0);
    step();
    exp_retire++;
    alu_op(5'd11, 32'h00000011, 1'b0);
    flush = 1'b1;
    hold = 1'b1;
    step();
    idle();
    checks++;
    if (out_regwe !== 1'b0) begin
      $display("FAIL flush_no_wb got we=%b want 0", out_regwe);
      errors++;
    end
    step();
    checks++;
    if (retire_cnt !== 32'(exp_retire)) begin
      $display("FAIL flush_retire got %0d want %0d", retire_cnt, exp_retire);
      errors++;
    end
  endtask

  task automatic test_zero_reg();
    alu_op(5'd0, 32'hCAFEF00D, 1'b0);
    step();
    idle();
    exp_retire++;
    checks++;
    if (out_regwe !== 1'b0) begin
      $display("FAIL zero_reg_we got %b want 0", out_regwe);
      errors++;
    end
    step();
    checks++;
    if (retire_cnt !== 32'(exp_retire) || n_retire_cnt !== 32'(exp_retire)) begin
      $display("FAIL zero_reg_retire got %0d/%0d want %0d", retire_cnt, n_retire_cnt, exp_retire);
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    alu_op(5'd12, 32'h0000BEEF, 1'b1);
    step();
    rst = 1'b1;
    hold = 1'b1;
    step();
    checks++;
    if ({out_regwe, out_regdin, out_rw, ovf_exc} !== 39'h0) begin
      $display("FAIL rst_mid_outputs got we=%b din=%h rw=%0d exc=%b want 0", out_regwe, out_regdin, out_rw, ovf_exc);
      errors++;
    end
    checks++;
    if (retire_cnt !== 32'd0 || ovf_cnt !== 32'd0 || n_retire_cnt !== 32'd0) begin
      $display("FAIL rst_mid_counters got retire=%0d ovf=%0d nosup=%0d want 0", retire_cnt, ovf_cnt, n_retire_cnt);
      errors++;
    end
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_alu_writeback();
    test_load_align();
    test_overflow();
    test_hold();
    test_flush();
    test_zero_reg();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
